bin2bcd_seq: RTL



---
 rtl/bin2bcd_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready handshake.
// Also produces a leading-zero blanking mask and a saturation flag for the display.
module bin2bcd_seq #(
    parameter int IN_W   = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [IN_W-1:0]       i_bin,
    output logic                  o_valid,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic [DIGITS-1:0]     o_blank,
    output logic                  o_ovf
);

    localparam int AW = 4 * DIGITS;
    localparam int CW = $clog2(IN_W + 1);
    localparam logic [AW-1:0]     NINES     = {DIGITS{4'h9}};
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state, state_n;
    logic [AW-1:0]      acc, acc_n, acc_adj, res;
    logic [IN_W-1:0]    bin, bin_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic               ovf, ovf_n;
    logic               accept, ld_out;
    logic [DIGITS-1:0]  blank_n;
    logic [AW+IN_W-1:0] shifted;

    assign o_ready = (state != SHIFT);
    assign accept  = i_valid && o_ready;

    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5)
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
        end
    end

    // The top digit's MSB falls off the end; it marks a value >= 10^DIGITS
    assign shifted = {acc_adj[AW-2:0], bin, 1'b0};

    assign res = ovf ? NINES : acc;

    always_comb begin
        logic z;
        z       = 1'b1;
        blank_n = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            z          = z && (res[4*k +: 4] == 4'd0);
            blank_n[k] = z;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        bin_n   = bin;
        cnt_n   = cnt;
        ovf_n   = ovf;
        ld_out  = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                ld_out  = (state == DONE);
                state_n = IDLE;
                if (accept) begin
                    acc_n   = '0;
                    bin_n   = i_bin;
                    cnt_n   = CW'(IN_W);
                    ovf_n   = 1'b0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                acc_n = shifted[AW+IN_W-1:IN_W];
                bin_n = shifted[IN_W-1:0];
                ovf_n = ovf | acc_adj[AW-1];
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1))
                    state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            bin   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            bin   <= bin_n;
            cnt   <= cnt_n;
            ovf   <= ovf_n;
        end
    end

    // Display-facing outputs only move on the result pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_bcd   <= '0;
            o_blank <= BLANK_RST;
            o_ovf   <= 1'b0;
        end else begin
            o_valid <= ld_out;
            if (ld_out) begin
                o_bcd   <= res;
                o_blank <= blank_n;
                o_ovf   <= ovf;
            end
        end
    end

endmodule
